// File: rtl/motion_decision_if.sv
// ============================================================================
//  Module      : motion_decision_if
//  Description : Frame-evaluation bus between the frame-difference counter
//                and the motion decision FSM, plus the decision outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface motion_decision_if #(
    parameter int CNT_W = 17
);
    logic             frame_done;
    logic [CNT_W-1:0] diff_pixel_cnt;
    logic             motion_detected;
    logic             motion_start;
    logic             motion_end;
    logic [CNT_W-1:0] frame_cnt_latched;
    logic [7:0]       event_cnt;

    modport master (
        output frame_done,
        output diff_pixel_cnt,
        input  motion_detected,
        input  motion_start,
        input  motion_end,
        input  frame_cnt_latched,
        input  event_cnt
    );

    modport slave (
        input  frame_done,
        input  diff_pixel_cnt,
        output motion_detected,
        output motion_start,
        output motion_end,
        output frame_cnt_latched,
        output event_cnt
    );
endinterface

`default_nettype wire

// File: rtl/motion_decision_fsm.sv
// ============================================================================
//  Module      : motion_decision_fsm
//  Description : Per-frame motion decision with threshold hysteresis,
//                multi-frame debounce and post-motion hold.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module motion_decision_fsm #(
    parameter int CNT_W       = 17,
    parameter int ON_THRESH   = 1500,
    parameter int OFF_THRESH  = 800,
    parameter int ON_FRAMES   = 3,
    parameter int OFF_FRAMES  = 5,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                 clk_25MHz,
    input  logic                 reset,
    motion_decision_if.slave     bus
);

    localparam int c_ON_W   = $clog2(ON_FRAMES + 1);
    localparam int c_OFF_W  = $clog2(OFF_FRAMES + 1);
    localparam int c_HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [CNT_W-1:0]    c_ON_TH     = CNT_W'(ON_THRESH);
    localparam logic [CNT_W-1:0]    c_OFF_TH    = CNT_W'(OFF_THRESH);
    localparam logic [c_ON_W-1:0]   c_ON_LAST   = c_ON_W'(ON_FRAMES);
    localparam logic [c_OFF_W-1:0]  c_OFF_LAST  = c_OFF_W'(OFF_FRAMES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        MOTION = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [c_ON_W-1:0]   r_on_cnt,   w_on_nx,   w_on_inc;
    logic [c_OFF_W-1:0]  r_off_cnt,  w_off_nx,  w_off_inc;
    logic [c_HOLD_W-1:0] r_hold_cnt, w_hold_nx, w_hold_inc;
    logic                w_active;
    logic                w_quiet;
    logic                w_start;
    logic                w_end;

    logic                r_motion_detected;
    logic                r_motion_start;
    logic                r_motion_end;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [7:0]          r_event_cnt;

    // Hysteresis: inclusive on the ON side only, counts between are neither
    assign w_active   = (bus.diff_pixel_cnt >= c_ON_TH);
    assign w_quiet    = (bus.diff_pixel_cnt <  c_OFF_TH);
    assign w_on_inc   = r_on_cnt   + c_ON_W'(1);
    assign w_off_inc  = r_off_cnt  + c_OFF_W'(1);
    assign w_hold_inc = r_hold_cnt + c_HOLD_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_on_nx    = r_on_cnt;
        w_off_nx   = r_off_cnt;
        w_hold_nx  = r_hold_cnt;
        w_start    = 1'b0;
        w_end      = 1'b0;
        if (bus.frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_active) begin
                        if (ON_FRAMES == 1) begin
                            w_state_nx = MOTION;
                            w_start    = 1'b1;
                        end else begin
                            w_state_nx = ARMING;
                            w_on_nx    = c_ON_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (w_active) begin
                        if (w_on_inc == c_ON_LAST) begin
                            w_state_nx = MOTION;
                            w_start    = 1'b1;
                            w_on_nx    = '0;
                        end else begin
                            w_on_nx    = w_on_inc;
                        end
                    end else begin
                        w_state_nx = IDLE;
                        w_on_nx    = '0;
                    end
                end
                MOTION: begin
                    if (w_quiet) begin
                        if (w_off_inc == c_OFF_LAST) begin
                            w_state_nx = HOLD;
                            w_off_nx   = '0;
                            w_hold_nx  = '0;
                        end else begin
                            w_off_nx   = w_off_inc;
                        end
                    end else begin
                        w_off_nx = '0;
                    end
                end
                HOLD: begin
                    // Re-trigger during hold continues the same event
                    if (w_active) begin
                        w_state_nx = MOTION;
                        w_hold_nx  = '0;
                    end else if (w_hold_inc == c_HOLD_LAST) begin
                        w_state_nx = IDLE;
                        w_end      = 1'b1;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx  = w_hold_inc;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_on_nx    = '0;
                    w_off_nx   = '0;
                    w_hold_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_on_cnt          <= '0;
            r_off_cnt         <= '0;
            r_hold_cnt        <= '0;
            r_motion_detected <= 1'b0;
            r_motion_start    <= 1'b0;
            r_motion_end      <= 1'b0;
            r_frame_cnt       <= '0;
            r_event_cnt       <= '0;
        end else begin
            r_state           <= w_state_nx;
            r_on_cnt          <= w_on_nx;
            r_off_cnt         <= w_off_nx;
            r_hold_cnt        <= w_hold_nx;
            r_motion_detected <= (w_state_nx == MOTION) || (w_state_nx == HOLD);
            r_motion_start    <= w_start;
            r_motion_end      <= w_end;
            if (bus.frame_done) begin
                r_frame_cnt <= bus.diff_pixel_cnt;
            end
            if (w_start && (r_event_cnt != 8'hFF)) begin
                r_event_cnt <= r_event_cnt + 8'd1;
            end
        end
    end

    assign bus.motion_detected   = r_motion_detected;
    assign bus.motion_start      = r_motion_start;
    assign bus.motion_end        = r_motion_end;
    assign bus.frame_cnt_latched = r_frame_cnt;
    assign bus.event_cnt         = r_event_cnt;

endmodule

`default_nettype wire

// File: tb/tb_motion_decision_fsm.sv
// ============================================================================
//  Module      : tb_motion_decision_fsm
//  Description : Self-checking bench for motion_decision_fsm against a
//                streak-counting reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_motion_decision_fsm;

    localparam int CNT_W       = 17;
    localparam int ON_THRESH   = 1500;
    localparam int OFF_THRESH  = 800;
    localparam int ON_FRAMES   = 3;
    localparam int OFF_FRAMES  = 5;
    localparam int HOLD_FRAMES = 30;

    logic clk_25MHz = 1'b0;
    logic reset     = 1'b0;

    motion_decision_if #(.CNT_W(CNT_W)) bus ();

    motion_decision_fsm #(
        .CNT_W      (CNT_W),
        .ON_THRESH  (ON_THRESH),
        .OFF_THRESH (OFF_THRESH),
        .ON_FRAMES  (ON_FRAMES),
        .OFF_FRAMES (OFF_FRAMES),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .reset    (reset),
        .bus      (bus)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: motion is a boolean plus run lengths of frame kinds
    bit               m_motion, m_hold;
    int               m_on_run, m_off_run, m_hold_run;
    logic             e_start, e_end;
    logic [CNT_W-1:0] e_latched;
    logic [7:0]       e_event;

    logic [27:0] got, expv;
    assign got  = {bus.motion_detected, bus.motion_start, bus.motion_end,
                   bus.frame_cnt_latched, bus.event_cnt};
    assign expv = {m_motion, e_start, e_end, e_latched, e_event};

    task automatic model_reset();
        m_motion = 0; m_hold = 0;
        m_on_run = 0; m_off_run = 0; m_hold_run = 0;
        e_start = 0; e_end = 0; e_latched = '0; e_event = '0;
    endtask

    task automatic model_frame(input int cnt);
        bit act, quiet;
        act = (cnt >= ON_THRESH);
        quiet = (cnt < OFF_THRESH);
        e_start = 0; e_end = 0;
        e_latched = CNT_W'(cnt);
        if (!m_motion) begin
            m_on_run = act ? m_on_run + 1 : 0;
            if (m_on_run == ON_FRAMES) begin
                m_motion = 1; m_on_run = 0; e_start = 1;
                if (e_event < 8'd255) e_event = e_event + 8'd1;
            end
        end else if (!m_hold) begin
            m_off_run = quiet ? m_off_run + 1 : 0;
            if (m_off_run == OFF_FRAMES) begin
                m_hold = 1; m_off_run = 0; m_hold_run = 0;
            end
        end else if (act) begin
            m_hold = 0; m_hold_run = 0;
        end else begin
            m_hold_run++;
            if (m_hold_run == HOLD_FRAMES) begin
                m_hold = 0; m_motion = 0; e_end = 1;
            end
        end
    endtask

    // Drive one clock of stimulus starting at a falling edge; returns at the next one
    task automatic step(input bit fd, input int cnt);
        bus.frame_done = fd;
        bus.diff_pixel_cnt = CNT_W'(cnt);
        if (fd) model_frame(cnt);
        else begin e_start = 0; e_end = 0; end
        @(negedge clk_25MHz);
        bus.frame_done = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.frame_done = 1'($urandom_range(0, 1));
            bus.diff_pixel_cnt = CNT_W'(2000);
            @(negedge clk_25MHz);
        end
        reset = 1'b1;
        bus.frame_done = 1'b0;
        model_reset();
    endtask

    function automatic int pick(input int regime);
        int r, v;
        r = int'($urandom_range(0, 99));
        if (r < 10) begin
            case ($urandom_range(0, 5))
                0: v = 799;   1: v = 800;  2: v = 1499;
                3: v = 1500;  4: v = 0;    default: v = 131071;
            endcase
        end else begin
            if (r < 18) regime = int'($urandom_range(0, 2));
            case (regime)
                0:       v = int'($urandom_range(1500, 20000));
                1:       v = int'($urandom_range(0, 799));
                default: v = int'($urandom_range(800, 1499));
            endcase
        end
        return v;
    endfunction

    task automatic test_reset();
        do_reset(4);
        n_vec++;
        if (got !== 28'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", got, 28'd0);
        end
        for (int i = 0; i < 100; i++) begin
            step(0, 0);
            n_vec++;
            if (got !== 28'd0) begin
                n_err++;
                $display("FAIL idle_after_reset cycle %0d: got %h expected %h", i, got, 28'd0);
            end
        end
    endtask

    task automatic test_arm_fire();
        int q[$] = '{1500, 1600, 2000};
        do_reset(2);
        foreach (q[i]) begin
            step(1, q[i]);
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL arm_fire frame %0d: got %h expected %h", i, got, expv);
            end
        end
        n_vec++;
        if (got !== {1'b1, 1'b1, 1'b0, 17'd2000, 8'd1}) begin
            n_err++;
            $display("FAIL arm_fire_start: got %h expected %h", got, {1'b1, 1'b1, 1'b0, 17'd2000, 8'd1});
        end
        step(0, 0);
        n_vec++;
        if (got !== {1'b1, 1'b0, 1'b0, 17'd2000, 8'd1}) begin
            n_err++;
            $display("FAIL arm_fire_pulse_width: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 17'd2000, 8'd1});
        end
    endtask

    task automatic test_broken_arming();
        int q[$] = '{1600, 1600, 1000, 1600, 1600};
        do_reset(2);
        foreach (q[i]) begin
            step(1, q[i]);
            n_vec++;
            if (got !== expv || bus.motion_detected !== 1'b0) begin
                n_err++;
                $display("FAIL broken_arming frame %0d: got %h expected %h", i, got, expv);
            end
        end
    endtask

    task automatic test_hysteresis_hold();
        int q[$];
        int ends = 0;
        do_reset(2);
        q = '{1600, 1600, 1600, 799, 799, 799, 799, 900};
        for (int i = 0; i < 5 + HOLD_FRAMES; i++) q.push_back(100);
        foreach (q[i]) begin
            step(1, q[i]);
            if (bus.motion_end === 1'b1) ends++;
            n_vec++;
            if (got !== expv || (i >= 2 && i < q.size() - 1 && bus.motion_detected !== 1'b1)) begin
                n_err++;
                $display("FAIL hysteresis_hold frame %0d: got %h expected %h", i, got, expv);
            end
        end
        n_vec++;
        if (ends !== 1 || bus.motion_end !== 1'b1 || bus.motion_detected !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: got ends=%0d end=%b motion=%b expected ends=1 end=1 motion=0",
                     ends, bus.motion_end, bus.motion_detected);
        end
    endtask

    task automatic test_retrigger();
        int ends = 0;
        do_reset(2);
        for (int i = 0; i < ON_FRAMES + OFF_FRAMES + 10; i++) step(1, i < ON_FRAMES ? 3000 : 50);
        step(1, 1500);
        n_vec++;
        if (got !== expv || bus.motion_start !== 1'b0 || bus.event_cnt !== 8'd1 || bus.motion_detected !== 1'b1) begin
            n_err++;
            $display("FAIL retrigger: got %h expected %h", got, expv);
        end
        for (int i = 0; i < OFF_FRAMES + HOLD_FRAMES + 3; i++) begin
            step(1, 20);
            if (bus.motion_end === 1'b1) ends++;
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL retrigger_release frame %0d: got %h expected %h", i, got, expv);
            end
        end
        n_vec++;
        if (ends !== 1) begin
            n_err++;
            $display("FAIL retrigger_end_count: got %0d expected 1", ends);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        step(1, 1600);
        step(1, 1600);
        do_reset(2);
        for (int i = 0; i < 2; i++) begin
            step(1, 1600);
            n_vec++;
            if (got !== expv || bus.motion_detected !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid frame %0d: got %h expected %h", i, got, expv);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset(2);
        for (int ev = 0; ev < 260; ev++) begin
            for (int f = 0; f < ON_FRAMES + OFF_FRAMES + HOLD_FRAMES; f++) begin
                step(1, f < ON_FRAMES ? 5000 : 10);
                n_vec++;
                if (got !== expv) begin
                    n_err++;
                    $display("FAIL saturation event %0d frame %0d: got %h expected %h", ev, f, got, expv);
                end
            end
        end
        n_vec++;
        if (bus.event_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL event_saturate: got %0d expected 255", bus.event_cnt);
        end
    endtask

    task automatic test_random();
        int regime, len;
        do_reset(2);
        for (int seg = 0; seg < 80; seg++) begin
            regime = int'($urandom_range(0, 2));
            len = int'($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) do_reset(int'($urandom_range(1, 3)));
            for (int f = 0; f < len; f++) begin
                step(1, pick(regime));
                n_vec++;
                if (got !== expv) begin
                    n_err++;
                    $display("FAIL random seg %0d frame %0d: got %h expected %h", seg, f, got, expv);
                end
                for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                    step(0, pick(regime));
                    n_vec++;
                    if (got !== expv) begin
                        n_err++;
                        $display("FAIL random_gap seg %0d frame %0d: got %h expected %h", seg, f, got, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.frame_done = 1'b0;
        bus.diff_pixel_cnt = '0;
        model_reset();
        @(negedge clk_25MHz);
        test_reset();
        test_arm_fire();
        test_broken_arming();
        test_hysteresis_hold();
        test_retrigger();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
